uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte-stream requesters. Requester 0 is the loopback echo path; requester 1 is the status/result reporter. Each requester sends bytes with a valid/ready handshake. A `last` flag locks ownership, so a multi-byte message is never interleaved with bytes from the other requester. The block sits between the requesters and the UART transmitter in the 96 MHz `clk` domain and issues one `tx_start` per byte.

---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one UART transmitter between two byte-stream requesters.
//             Requester 0 is the loopback echo path, requester 1 the
//             status/result reporter. Ownership is locked from the first byte
//             of a packet until the byte flagged `last`. A lock held by a
//             stalled owner is revoked after LOCK_TIMEOUT idle cycles.
//             Contention between packets is resolved round-robin.
//  Ports    : clk, reset            - 96 MHz clock, synchronous active-high reset
//             reqN_data/valid/last  - requester N byte, handshake and packet end
//             reqN_ready            - requester N byte accepted this cycle
//             tx_busy               - UART transmitter is shifting a byte
//             tx_data, tx_start     - byte and one-cycle start pulse to the UART
//             grant                 - one-hot owner, 00 when nobody owns the UART
//             timeout_err           - one-cycle pulse when a lock is revoked
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int LOCK_TIMEOUT = 96_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int                 c_CNT_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy_first;  // first BUSY cycle: UART has not raised tx_busy yet
    logic               r_last;        // `last` of the byte currently in flight
    logic               r_rr_last;     // index of the requester served last
    logic [c_CNT_W-1:0] r_cnt;         // stall counter while holding the lock
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic [1:0]         r_grant;
    logic               r_timeout_err;

    logic w_sel0;
    logic w_sel1;
    logic w_ready0;
    logic w_ready1;
    logic w_xfer0;
    logic w_xfer1;
    logic w_owner;
    logic [7:0] w_cap_data;
    logic       w_cap_last;

    // Round-robin selection: a lone valid requester wins outright; on
    // contention the requester that was not served last wins.
    assign w_sel0 = req0_valid && (!req1_valid ||  r_rr_last);
    assign w_sel1 = req1_valid && (!req0_valid || !r_rr_last);

    // In IDLE a requester is ready unless the other one is the selected one.
    // With neither valid both readies are high; only a valid requester can
    // then transfer, so at most one transfer happens per edge.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready0 = !tx_busy && !w_sel1;
                w_ready1 = !tx_busy && !w_sel0;
            end
            S_HOLD: begin
                w_ready0 = !tx_busy && r_grant[0];
                w_ready1 = !tx_busy && r_grant[1];
            end
            default: begin
                w_ready0 = 1'b0;
                w_ready1 = 1'b0;
            end
        endcase
    end

    assign w_xfer0    = req0_valid && w_ready0;
    assign w_xfer1    = req1_valid && w_ready1;
    assign w_owner    = r_grant[1];
    assign w_cap_data = w_xfer1 ? req1_data : req0_data;
    assign w_cap_last = w_xfer1 ? req1_last : req0_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_busy_first  <= 1'b0;
            r_last        <= 1'b0;
            r_rr_last     <= 1'b1;
            r_cnt         <= '0;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_grant       <= 2'b00;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer0 || w_xfer1) begin
                        r_tx_data  <= w_cap_data;
                        r_last     <= w_cap_last;
                        r_grant    <= {w_xfer1, w_xfer0};
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_busy_first <= 1'b1;
                    r_state      <= S_BUSY;
                end
                S_BUSY: begin
                    r_busy_first <= 1'b0;
                    // tx_busy only rises one cycle after tx_start, so the
                    // first BUSY cycle must not be mistaken for completion.
                    if (!r_busy_first && !tx_busy) begin
                        if (r_last) begin
                            r_rr_last <= w_owner;
                            r_grant   <= 2'b00;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_xfer0 || w_xfer1) begin
                        r_tx_data  <= w_cap_data;
                        r_last     <= w_cap_last;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_rr_last     <= w_owner;
                        r_grant       <= 2'b00;
                        r_state       <= S_IDLE;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter with a simple
//             UART busy model (80 cycles per frame) and a start-byte log.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int LOCK_TIMEOUT = 16;
    localparam int FRAME        = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_last = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_last = 1'b0;
    logic       req1_ready;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] grant;
    logic       timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_data   (req0_data),
        .req0_valid  (req0_valid),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_data   (req1_data),
        .req1_valid  (req1_valid),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    // UART model: busy for FRAME cycles starting the cycle after tx_start;
    // a reset of the arbiter does not abort the byte on the line.
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    logic [7:0] log_q[$];
    always @(posedge clk) if (tx_start) log_q.push_back(tx_data);

    int lock_viol = 0;
    always @(posedge clk)
        if (!reset && ((grant[0] && req1_ready) || (grant[1] && req0_ready)))
            lock_viol <= lock_viol + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_line_idle();
        int n = 0;
        while (tx_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("line_idle", tx_busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_line_idle();
    endtask

    // Called at a negedge; returns at the negedge of the START cycle.
    task automatic send(input int port, input logic [7:0] d, input logic l, input int max);
        int n = 0;
        logic rdy;
        if (port == 0) begin
            req0_data = d; req0_last = l; req0_valid = 1'b1;
        end else begin
            req1_data = d; req1_last = l; req1_valid = 1'b1;
        end
        #1;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && n < max) begin
            @(negedge clk);
            #1;
            rdy = (port == 0) ? req0_ready : req1_ready;
            n++;
        end
        check($sformatf("accept_p%0d_%02h", port, d), rdy, 1'b1);
        @(negedge clk);
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic wait_log(input int cnt, input int max);
        int n = 0;
        while (log_q.size() < cnt && n < max) begin
            @(negedge clk);
            n++;
        end
        check("log_count", log_q.size(), cnt);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hDEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_seen;
        int st_seen;
        logic [7:0] exp_ord [4];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_ready0", req0_ready, 1'b1);
        check("rst_ready1", req1_ready, 1'b1);

        // ---------------- single byte ----------------
        @(negedge clk);
        req0_data = 8'hAA; req0_last = 1'b1; req0_valid = 1'b1;
        #1;
        check("single_ready0", req0_ready, 1'b1);
        check("single_ready1", req1_ready, 1'b0);
        @(negedge clk);
        check("single_tx_start", tx_start, 1'b1);
        check("single_tx_data", tx_data, 8'hAA);
        check("single_grant", grant, 2'b01);
        req0_valid = 1'b0;
        n = 0;
        while (grant != 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 40) begin
                check("single_grant_mid", grant, 2'b01);
                check("single_busy_mid", tx_busy, 1'b1);
            end
        end
        check("single_release_cycles", n, 82);
        check("single_tx_data_held", tx_data, 8'hAA);

        // ---------------- contention alternation ----------------
        do_reset();
        log_q.delete();
        req0_data = 8'hAA; req0_last = 1'b1; req0_valid = 1'b1;
        req1_data = 8'hBB; req1_last = 1'b1; req1_valid = 1'b1;
        wait_log(4, 1000);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_ord = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};
        for (int i = 0; i < 4; i++)
            check($sformatf("contention_byte%0d", i), log_at(i), {24'h0, exp_ord[i]});

        // ---------------- packet lock ----------------
        do_reset();
        log_q.delete();
        req1_data = 8'hBB; req1_last = 1'b1; req1_valid = 1'b1;
        send(0, 8'h11, 1'b0, 300);
        send(0, 8'h22, 1'b0, 300);
        send(0, 8'h33, 1'b1, 300);
        wait_log(4, 300);
        req1_valid = 1'b0;
        exp_ord = '{8'h11, 8'h22, 8'h33, 8'hBB};
        for (int i = 0; i < 4; i++)
            check($sformatf("lock_byte%0d", i), log_at(i), {24'h0, exp_ord[i]});

        // ---------------- timeout ----------------
        do_reset();
        send(1, 8'h55, 1'b0, 50);
        check("to_tx_start", tx_start, 1'b1);
        check("to_grant1", grant, 2'b10);
        req0_data = 8'hAA; req0_last = 1'b1; req0_valid = 1'b1;
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_pulse_cycles", n, 98);
        check("to_grant_cleared", grant, 2'b00);
        @(negedge clk);
        check("to_pulse_width", timeout_err, 1'b0);
        check("to_req0_start", tx_start, 1'b1);
        check("to_req0_data", tx_data, 8'hAA);
        check("to_req0_grant", grant, 2'b01);
        req0_valid = 1'b0;

        // ---------------- external busy ----------------
        do_reset();
        force_busy = 1'b1;
        req0_data = 8'h55; req0_last = 1'b1; req0_valid = 1'b1;
        rdy_seen = 0;
        st_seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req0_ready) rdy_seen++;
            if (tx_start)   st_seen++;
            @(negedge clk);
        end
        check("xbusy_no_ready", rdy_seen, 0);
        check("xbusy_no_start", st_seen, 0);
        force_busy = 1'b0;
        #1;
        check("xbusy_ready_on_fall", req0_ready, 1'b1);
        @(negedge clk);
        check("xbusy_tx_start", tx_start, 1'b1);
        check("xbusy_tx_data", tx_data, 8'h55);
        req0_valid = 1'b0;

        // ---------------- reset during BUSY ----------------
        n = 0;
        while (grant != 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        send(0, 8'h77, 1'b1, 50);
        repeat (10) @(negedge clk);
        check("rb_grant_before", grant, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rb_grant", grant, 2'b00);
        check("rb_tx_start", tx_start, 1'b0);
        check("rb_tx_data", tx_data, 8'h00);
        check("rb_timeout_err", timeout_err, 1'b0);
        log_q.delete();
        req0_data = 8'h12; req0_last = 1'b1; req0_valid = 1'b1;
        req1_data = 8'h34; req1_last = 1'b1; req1_valid = 1'b1;
        wait_log(1, 300);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rb_first_winner", log_at(0), 32'h12);

        @(negedge clk);
        check("lock_never_shared", lock_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
